cla_operand_loader: RTL and testbench

//  Upstream operand stage for the 64-bit registered CLA adder (CLA_64).

---
 rtl/cla_operand_loader_if.sv | 18 +
 rtl/cla_operand_loader.sv | 114 +++++++++++
 tb/tb_cla_operand_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cla_operand_loader_if.sv
// cla_operand_loader_if: beat input stream and result handshake of the operand loader
interface cla_operand_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_sum;
    logic        res_cout;
    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_sum, res_cout
    );
    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_sum, res_cout
    );
endinterface

// File: rtl/cla_operand_loader.sv
// cla_operand_loader: assembles 64-bit operands from 32-bit beats, waits out the CLA latency, holds the result
module cla_operand_loader #(
    parameter int CLA_LAT = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    cla_operand_loader_if.slave         s_bus,
    output logic [63:0]                 o_op1,
    output logic [63:0]                 o_op2,
    input  logic [63:0]                 i_cla_sum,
    input  logic                        i_cla_cout,
    output logic                        o_busy
);
    localparam int LW = (CLA_LAT > 1) ? $clog2(CLA_LAT) : 1;
    typedef enum logic [1:0] {LOAD, WAIT, HOLD} state_t;
    state_t        r_state, w_state_nxt;
    logic [1:0]    r_beat_cnt, w_beat_cnt_nxt;
    logic [LW-1:0] r_lat_cnt, w_lat_cnt_nxt;
    logic [95:0]   r_shadow, w_shadow_nxt;
    logic [63:0]   r_op1, r_op2, w_op1_nxt, w_op2_nxt;
    logic [63:0]   r_res_sum, w_res_sum_nxt;
    logic          r_res_cout, w_res_cout_nxt;
    logic          r_res_valid, w_res_valid_nxt;
    logic          r_in_ready, w_in_ready_nxt;
    logic          r_busy, w_busy_nxt;
    logic          w_accept, w_last, w_pop, w_lat_done;
    assign w_accept   = s_bus.in_valid & r_in_ready;
    assign w_last     = w_accept & (r_beat_cnt == 2'd3);
    assign w_pop      = r_res_valid & s_bus.res_ready;
    assign w_lat_done = r_lat_cnt == LW'(CLA_LAT - 1);
    assign s_bus.in_ready  = r_in_ready;
    assign s_bus.res_valid = r_res_valid;
    assign s_bus.res_sum   = r_res_sum;
    assign s_bus.res_cout  = r_res_cout;
    assign o_op1  = r_op1;
    assign o_op2  = r_op2;
    assign o_busy = r_busy;
    // Next-state and next-register values; beats 0-2 park in the shadow, beat 3 updates both operands at once
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_shadow_nxt    = r_shadow;
        w_op1_nxt       = r_op1;
        w_op2_nxt       = r_op2;
        w_res_sum_nxt   = r_res_sum;
        w_res_cout_nxt  = r_res_cout;
        w_res_valid_nxt = r_res_valid;
        w_in_ready_nxt  = r_in_ready;
        w_busy_nxt      = r_busy;
        case (r_state)
            LOAD: begin
                w_in_ready_nxt = !w_last;
                if (w_last) begin
                    w_op1_nxt      = r_shadow[63:0];
                    w_op2_nxt      = {s_bus.in_data, r_shadow[95:64]};
                    w_state_nxt    = WAIT;
                    w_busy_nxt     = 1'b1;
                    w_lat_cnt_nxt  = '0;
                    w_beat_cnt_nxt = 2'd0;
                end else if (w_accept) begin
                    w_shadow_nxt[{r_beat_cnt, 5'd0} +: 32] = s_bus.in_data;
                    w_beat_cnt_nxt = r_beat_cnt + 2'd1;
                end
            end
            WAIT: begin
                w_lat_cnt_nxt = r_lat_cnt + LW'(1);
                if (w_lat_done) begin
                    w_res_sum_nxt   = i_cla_sum;
                    w_res_cout_nxt  = i_cla_cout;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = HOLD;
                end
            end
            HOLD: begin
                if (w_pop) begin
                    w_res_valid_nxt = 1'b0;
                    w_busy_nxt      = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_state_nxt     = LOAD;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end
    // State registers; reset clears everything immediately, including in_ready
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= LOAD;
            r_beat_cnt  <= 2'd0;
            r_lat_cnt   <= '0;
            r_shadow    <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_shadow    <= w_shadow_nxt;
            r_op1       <= w_op1_nxt;
            r_op2       <= w_op2_nxt;
            r_res_sum   <= w_res_sum_nxt;
            r_res_cout  <= w_res_cout_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end
endmodule

// File: tb/tb_cla_operand_loader.sv
// tb_cla_operand_loader: directed checks of beat assembly, latency, backpressure and async reset
module tb_cla_operand_loader;
    localparam int LAT = 2;
    logic        clk;
    logic        rst_n;
    logic [63:0] op1, op2, cla_sum;
    logic        cla_cout, busy;
    logic [64:0] r_cla;
    int          n_pass = 0;
    int          n_total = 0;
    cla_operand_loader_if bus();
    cla_operand_loader #(.CLA_LAT(LAT)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .s_bus      (bus),
        .o_op1      (op1),
        .o_op2      (op2),
        .i_cla_sum  (cla_sum),
        .i_cla_cout (cla_cout),
        .o_busy     (busy)
    );
    initial clk = 1'b0;
    always #4 clk = ~clk;
    // Adder model: one output register, so the sum sampled LAT edges after an operand update is valid
    always_ff @(posedge clk) r_cla <= {1'b0, op1} + {1'b0, op2};
    assign cla_sum  = r_cla[63:0];
    assign cla_cout = r_cla[64];
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic send_beat(input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("beat_ready_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask
    task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input bit gapped,
                           input logic [63:0] exp_sum, input logic exp_cout);
        logic [63:0] p1, p2;
        logic [31:0] beats [4];
        p1 = op1;
        p2 = op2;
        beats[0] = a[31:0];
        beats[1] = a[63:32];
        beats[2] = b[31:0];
        beats[3] = b[63:32];
        for (int i = 0; i < 4; i++) begin
            send_beat(beats[i]);
            if (i < 3) begin
                check("op1_hold_beat", op1, p1);
                check("op2_hold_beat", op2, p2);
                if (gapped) begin
                    @(negedge clk);
                    check("op1_hold_gap", op1, p1);
                end
            end
        end
        check("op1_load", op1, a);
        check("op2_load", op2, b);
        check("in_ready_wait", 64'(bus.in_ready), 64'd0);
        check("busy_wait", 64'(busy), 64'd1);
        check("res_valid_early0", 64'(bus.res_valid), 64'd0);
        for (int i = 0; i < LAT - 1; i++) begin
            @(posedge clk);
            #1;
            check("res_valid_early", 64'(bus.res_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        check("res_valid_rise", 64'(bus.res_valid), 64'd1);
        check("res_sum", bus.res_sum, exp_sum);
        check("res_cout", 64'(bus.res_cout), 64'(exp_cout));
        check("busy_hold", 64'(busy), 64'd1);
    endtask
    task automatic take_result(input int stall, input logic [63:0] exp_sum, input logic exp_cout,
                               input logic [63:0] a);
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hdead_0000 + 32'(i);
            @(posedge clk);
            #1;
            check("bp_res_valid", 64'(bus.res_valid), 64'd1);
            check("bp_res_sum", bus.res_sum, exp_sum);
            check("bp_res_cout", 64'(bus.res_cout), 64'(exp_cout));
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("pop_res_valid", 64'(bus.res_valid), 64'd0);
        check("pop_busy", 64'(busy), 64'd0);
        check("pop_in_ready", 64'(bus.in_ready), 64'd1);
        check("pop_op1_hold", op1, a);
    endtask
    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.res_ready = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_op1", op1, 64'd0);
        check("rst_op2", op2, 64'd0);
        check("rst_res_sum", bus.res_sum, 64'd0);
        #5 rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 64'(bus.in_ready), 64'd1);
        run_txn(64'h1234_ffff_dfff_eeee, 64'hdddd_dddd_dddd_dddd, 1'b0, 64'hf012_dddd_bddd_cccb, 1'b0);
        take_result(0, 64'hf012_dddd_bddd_cccb, 1'b0, 64'h1234_ffff_dfff_eeee);
        run_txn(64'hffff_ffff_ffff_ffff, 64'h0000_0000_0000_0001, 1'b0, 64'h0, 1'b1);
        take_result(5, 64'h0, 1'b1, 64'hffff_ffff_ffff_ffff);
        run_txn(64'h1234_ffff_dfff_eeee, 64'hdddd_dddd_dddd_dddd, 1'b1, 64'hf012_dddd_bddd_cccb, 1'b0);
        take_result(1, 64'hf012_dddd_bddd_cccb, 1'b0, 64'h1234_ffff_dfff_eeee);
        send_beat(32'h1111_1111);
        send_beat(32'h2222_2222);
        send_beat(32'h3333_3333);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_op1", op1, 64'd0);
        check("midrst_op2", op2, 64'd0);
        check("midrst_res_sum", bus.res_sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(64'h0000_0001_8000_0000, 64'h0000_0000_8000_0000, 1'b0, 64'h0000_0002_0000_0000, 1'b0);
        take_result(0, 64'h0000_0002_0000_0000, 1'b0, 64'h0000_0001_8000_0000);
        run_txn(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0005, 1'b0, 64'h0000_0000_0000_0005, 1'b1);
        take_result(2, 64'h0000_0000_0000_0005, 1'b1, 64'h8000_0000_0000_0000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
